// File: rtl/adc_spi_reader.sv
// -----------------------------------------------------------------------------
// adc_spi_reader
//
// SPI master for four simultaneously-sampled serial ADCs that share one
// chip-select and one SCLK, each with its own MISO line. A period counter
// starts one conversion frame every SAMPLE_PERIOD clocks while enable_in is
// high. Each frame is FRAME_BITS SCLK cycles long. The low SAMPLE_BITS bits of
// each frame are offset-binary data, which is converted to a signed 16-bit
// sample and presented together with a one-cycle valid strobe.
//
// Ports:
//   clk_in       system clock
//   rst_n        asynchronous active-low reset
//   enable_in    run periodic sampling
//   miso_in      serial data, one bit per ADC (sampled on SCLK rising edge)
//   sclk_out     SPI clock, idles high
//   cs_n_out     shared chip-select, active low
//   adc_out      latest converted sample per channel (signed 16-bit each)
//   valid_out    one-cycle strobe when adc_out updates
//   overrun_out  sticky flag: a trigger arrived while a frame was in progress
// -----------------------------------------------------------------------------
module adc_spi_reader #(
   parameter int CLK_DIV       = 4,
   parameter int FRAME_BITS    = 16,
   parameter int SAMPLE_BITS   = 12,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic                    clk_in,
   input  logic                    rst_n,
   input  logic                    enable_in,
   input  logic [3:0]              miso_in,
   output logic                    sclk_out,
   output logic                    cs_n_out,
   output logic signed [3:0][15:0] adc_out,
   output logic                    valid_out,
   output logic                    overrun_out
);

   localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      QUIET,
      DONE
   } state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic [PER_W-1:0]                per_cnt;
   logic [DIV_W-1:0]                div_cnt;
   logic [BIT_W-1:0]                bit_cnt;
   logic [3:0][FRAME_BITS-1:0]      shift_reg;

   logic                            trigger;
   logic                            div_last;
   logic                            bit_last;
   logic                            shift_en;
   logic                            frame_end;

   // Offset-binary to two's complement: invert the MSB, then sign-extend.
   function automatic logic signed [15:0] offset_to_signed(
      input logic [SAMPLE_BITS-1:0] raw
   );
      logic signed [SAMPLE_BITS-1:0] twos;
      twos = signed'({~raw[SAMPLE_BITS-1], raw[SAMPLE_BITS-2:0]});
      return 16'(twos);
   endfunction

   assign trigger  = enable_in && (per_cnt == '0);
   assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign bit_last = (bit_cnt == BIT_W'(FRAME_BITS - 1));

   // Period counter: free-runs while enabled, parked at zero otherwise so the
   // first enabled cycle is always a trigger.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
      end else if (!enable_in) begin
         per_cnt <= '0;
      end else if (per_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + PER_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) state_nxt = SETUP;
         end
         SETUP: begin
            if (div_last) state_nxt = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (div_last) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            // First cycle of the high phase is the SCLK rising edge.
            shift_en = (div_cnt == '0);
            if (div_last) state_nxt = bit_last ? QUIET : SHIFT_LO;
         end
         QUIET: begin
            if (div_last) begin
               state_nxt = DONE;
               frame_end = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Phase timer restarts on every state change; bit counter counts LO/HI pairs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         if (state == IDLE || state_nxt != state) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (state == IDLE) begin
            bit_cnt <= '0;
         end else if (state == SHIFT_HI && div_last) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end
   end

   // Serial capture, MSB first.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
      end else if (shift_en) begin
         for (int ch = 0; ch < 4; ch++) begin
            shift_reg[ch] <= {shift_reg[ch][FRAME_BITS-2:0], miso_in[ch]};
         end
      end
   end

   // SPI pins are registered from the next state so they are glitch-free and
   // line up exactly with the state they represent.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sclk_out <= 1'b1;
         cs_n_out <= 1'b1;
      end else begin
         sclk_out <= (state_nxt != SHIFT_LO);
         cs_n_out <= !(state_nxt inside {SETUP, SHIFT_LO, SHIFT_HI});
      end
   end

   // Output samples are loaded on entry to DONE so valid_out and the new
   // adc_out values appear in the same cycle.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         adc_out     <= '0;
         valid_out   <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         valid_out <= frame_end;
         if (frame_end) begin
            for (int ch = 0; ch < 4; ch++) begin
               adc_out[ch] <= offset_to_signed(shift_reg[ch][SAMPLE_BITS-1:0]);
            end
         end
         if (trigger && state != IDLE) begin
            overrun_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_spi_reader.sv
`timescale 1ns/1ps
module tb_adc_spi_reader;

   localparam int CLK_DIV    = 4;
   localparam int FRAME_BITS = 16;
   localparam int CS_LEN     = CLK_DIV * (1 + 2 * FRAME_BITS);
   localparam int VLD_AT     = 1 + CLK_DIV * (2 + 2 * FRAME_BITS);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n;
   logic                    en;
   logic                    en_o;
   logic [3:0]              miso;
   logic [3:0]              miso_o;
   logic                    sclk, cs_n, valid, ovr;
   logic                    sclk_o, cs_n_o, valid_o, ovr_o;
   logic signed [3:0][15:0] adc;
   logic signed [3:0][15:0] adc_o;

   adc_spi_reader dut (
      .clk_in      (clk),
      .rst_n       (rst_n),
      .enable_in   (en),
      .miso_in     (miso),
      .sclk_out    (sclk),
      .cs_n_out    (cs_n),
      .adc_out     (adc),
      .valid_out   (valid),
      .overrun_out (ovr)
   );

   adc_spi_reader #(.SAMPLE_PERIOD(100)) dut_ovr (
      .clk_in      (clk),
      .rst_n       (rst_n),
      .enable_in   (en_o),
      .miso_in     (miso_o),
      .sclk_out    (sclk_o),
      .cs_n_out    (cs_n_o),
      .adc_out     (adc_o),
      .valid_out   (valid_o),
      .overrun_out (ovr_o)
   );

   // ADC model: each frame word is sent MSB first; a new bit appears on every
   // SCLK falling edge while selected.
   logic [3:0][15:0] words;
   int               bit_idx;
   always @(negedge cs_n or negedge sclk) begin
      if (sclk) begin
         bit_idx = FRAME_BITS;
      end else if (!cs_n && bit_idx > 0) begin
         bit_idx = bit_idx - 1;
         for (int ch = 0; ch < 4; ch++) miso[ch] = words[ch][bit_idx];
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0][15:0] w;
      logic [3:0][15:0] e;
   } vec_t;

   vec_t tbl [3];

   function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3,
                               input int e0, e1, e2, e3);
      vec_t v;
      v.w = {w3, w2, w1, w0};
      v.e = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
      return v;
   endfunction

   // Per-frame observations, cycle index i means cycle T+i after the trigger.
   int st_cs_cnt, st_cs_first, st_cs_last, st_rise, st_rise_bad, st_idle_bad;
   int st_vcnt, st_vidx;
   logic [3:0][15:0] st_adc;

   task automatic observe(input int ncyc, input bit pulse);
      logic prev_sclk;
      st_cs_cnt = 0; st_cs_first = -1; st_cs_last = -1; st_rise = 0;
      st_rise_bad = 0; st_idle_bad = 0; st_vcnt = 0; st_vidx = -1; st_adc = '0;
      prev_sclk = sclk;
      for (int i = 1; i <= ncyc; i++) begin
         @(posedge clk); #1;
         if (pulse && i == 1) en = 1'b0;
         if (!cs_n) begin
            st_cs_cnt++;
            if (st_cs_first < 0) st_cs_first = i;
            st_cs_last = i;
         end
         if (sclk && !prev_sclk) begin
            st_rise++;
            if (cs_n) st_rise_bad++;
         end
         if (cs_n && !sclk) st_idle_bad++;
         if (valid) begin
            st_vcnt++;
            if (st_vidx < 0) st_vidx = i;
            st_adc = adc;
         end
         prev_sclk = sclk;
      end
   endtask

   task automatic run_single(input logic [3:0][15:0] w);
      words = w;
      @(negedge clk);
      en = 1'b1;
      observe(VLD_AT + 20, 1'b1);
   endtask

   task automatic check_frame(input string tag, input logic [3:0][15:0] exp_adc);
      chk({tag, " cs_n low cycles"}, st_cs_cnt, CS_LEN);
      chk({tag, " cs_n first low"}, st_cs_first, 1);
      chk({tag, " cs_n last low"}, st_cs_last, CS_LEN);
      chk({tag, " sclk rises"}, st_rise, FRAME_BITS);
      chk({tag, " sclk rise with cs_n high"}, st_rise_bad, 0);
      chk({tag, " sclk low with cs_n high"}, st_idle_bad, 0);
      chk({tag, " valid pulses"}, st_vcnt, 1);
      chk({tag, " valid cycle"}, st_vidx, VLD_AT);
      for (int ch = 0; ch < 4; ch++) begin
         chk($sformatf("%s adc ch%0d at valid", tag, ch),
             $signed(st_adc[ch]), $signed(exp_adc[ch]));
         chk($sformatf("%s adc ch%0d held", tag, ch),
             $signed(adc[ch]), $signed(exp_adc[ch]));
      end
   endtask

   initial begin
      logic [3:0][15:0] rw;
      logic [3:0][15:0] rexp;
      int vq[$];
      int ovq[$];
      int ovr_seen, extra, ovr_first, ovr_drop, cs_o_cnt, rise_o, vcnt_abort;
      logic prev_sclk_o;

      tbl[0] = mk(16'h0800, 16'h0FFF, 16'h0000, 16'h0123, 0, 2047, -2048, -1757);
      tbl[1] = mk(16'hF800, 16'hFFFF, 16'hF000, 16'hF801, 0, 2047, -2048, 1);
      tbl[2] = mk(16'h0A5A, 16'h07FF, 16'h0801, 16'h0001, 602, -1, 1, -2047);

      rst_n = 1'b0; en = 1'b0; en_o = 1'b0; miso = 4'h0; miso_o = 4'h0;
      words = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset sclk", sclk, 1);
      chk("reset cs_n", cs_n, 1);
      chk("reset valid", valid, 0);
      chk("reset overrun", ovr, 0);
      for (int ch = 0; ch < 4; ch++)
         chk($sformatf("reset adc ch%0d", ch), $signed(adc[ch]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Directed vectors
      for (int k = 0; k < 3; k++) begin
         run_single(tbl[k].w);
         check_frame($sformatf("vec%0d", k), tbl[k].e);
      end

      // Random frames against arithmetic model: value = raw - midscale
      for (int k = 0; k < 6; k++) begin
         for (int ch = 0; ch < 4; ch++) begin
            rw[ch]   = 16'($urandom);
            rexp[ch] = 16'(int'(rw[ch][11:0]) - 2048);
         end
         run_single(rw);
         check_frame($sformatf("rand%0d", k), rexp);
      end

      // Continuous sampling for 3500 cycles
      words = tbl[2].w;
      ovr_seen = 0;
      @(negedge clk);
      en = 1'b1;
      for (int i = 1; i <= 3500; i++) begin
         @(posedge clk); #1;
         if (valid) vq.push_back(i);
         if (ovr) ovr_seen = 1;
      end
      en = 1'b0;
      extra = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (valid) extra++;
      end
      chk("continuous valid count", vq.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("continuous valid %0d cycle", k),
             (k < vq.size()) ? vq[k] : -1, VLD_AT + 1000 * k);
      chk("continuous overrun", ovr_seen, 0);
      chk("valid after disable", extra, 0);
      for (int ch = 0; ch < 4; ch++)
         chk($sformatf("continuous adc ch%0d", ch),
             $signed(adc[ch]), $signed(tbl[2].e[ch]));

      // Overrun with short sample period
      ovr_first = -1; ovr_drop = 0; cs_o_cnt = 0; rise_o = 0; ovr_seen = 0;
      prev_sclk_o = sclk_o;
      @(negedge clk);
      en_o = 1'b1;
      for (int i = 1; i <= 340; i++) begin
         @(posedge clk); #1;
         if (ovr_o && ovr_first < 0) ovr_first = i;
         if (ovr_first >= 0 && !ovr_o) ovr_drop++;
         if (valid_o) ovq.push_back(i);
         if (!cs_n_o) cs_o_cnt++;
         if (sclk_o && !prev_sclk_o) rise_o++;
         if (ovr) ovr_seen = 1;
         prev_sclk_o = sclk_o;
      end
      en_o = 1'b0;
      chk("overrun first set cycle (trigger at T+100)", ovr_first, 101);
      chk("overrun cleared without reset", ovr_drop, 0);
      chk("overrun valid count", ovq.size(), 2);
      chk("overrun valid 0 cycle", (ovq.size() > 0) ? ovq[0] : -1, VLD_AT);
      chk("overrun valid 1 cycle (T+200 accepted)", (ovq.size() > 1) ? ovq[1] : -1, 200 + VLD_AT);
      chk("overrun cs_n low cycles", cs_o_cnt, 2 * CS_LEN);
      chk("overrun sclk rises", rise_o, 2 * FRAME_BITS);
      chk("overrun leaked to other instance", ovr_seen, 0);
      for (int ch = 0; ch < 4; ch++)
         chk($sformatf("overrun dut adc ch%0d", ch), $signed(adc_o[ch]), -2048);

      // Reset mid-frame
      vcnt_abort = 0;
      @(negedge clk);
      en = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (valid) vcnt_abort++;
      end
      rst_n = 1'b0;
      #1;
      chk("midreset cs_n", cs_n, 1);
      chk("midreset sclk", sclk, 1);
      chk("midreset valid", valid, 0);
      chk("midreset overrun cleared", ovr_o, 0);
      for (int ch = 0; ch < 4; ch++)
         chk($sformatf("midreset adc ch%0d", ch), $signed(adc[ch]), 0);
      @(negedge clk);
      @(negedge clk);
      words = tbl[0].w;
      rst_n = 1'b1;
      observe(VLD_AT + 20, 1'b1);
      chk("aborted frame valid", vcnt_abort, 0);
      check_frame("after reset", tbl[0].e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
